load_shm: RTL

LOAD_SHM -- requirements
Module: load_shm

---
 rtl/load_shm_if.sv | 34 +++
 rtl/load_shm.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/load_shm_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_shm_if
//  Description : Request / memory / response bundle for the load_shm block.
//                The slave modport is the load unit's view of the bundle.
//                The master modport is the requester/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_shm_if;
    logic        ReqValid;
    logic        ReqReady;
    logic [31:0] Addr;
    logic [1:0]  Size;
    logic        Signed;
    logic        MemRd;
    logic [31:0] MemAddr;
    logic [3:0]  SelOut;
    logic        MemAck;
    logic [31:0] DataIn;
    logic        RespValid;
    logic [31:0] DataOut;
    logic        Err;

    modport slave (
        input  ReqValid, Addr, Size, Signed, MemAck, DataIn,
        output ReqReady, MemRd, MemAddr, SelOut, RespValid, DataOut, Err
    );

    modport master (
        output ReqValid, Addr, Size, Signed, MemAck, DataIn,
        input  ReqReady, MemRd, MemAddr, SelOut, RespValid, DataOut, Err
    );
endinterface
`default_nettype wire

// File: rtl/load_shm.sv
`default_nettype none
// ============================================================================
//  Module      : load_shm
//  Description : Single-outstanding load unit. Accepts a byte/half/word load,
//                issues one word read, then extracts and extends the addressed
//                lane. A wait counter aborts the read after TIMEOUT cycles.
//                Optional macro LOAD_SHM_MISALIGN_EN rejects misaligned
//                half/word loads with an immediate error response.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_shm #(
    parameter int TIMEOUT = 15
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    load_shm_if.slave   bus
);

    localparam logic [7:0] C_TIMEOUT = TIMEOUT[7:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_mem_rd;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_sel;
    logic        r_resp_valid;
    logic [31:0] r_data_out;
    logic        r_err;
    logic [7:0]  r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic        r_signed;

    logic        w_hs;
    logic        w_misalign;
    logic [3:0]  w_sel;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_hs      = bus.ReqValid && r_req_ready;
    assign w_cnt_nxt = r_cnt + 8'd1;

`ifdef LOAD_SHM_MISALIGN_EN
    assign w_misalign = ((bus.Size == 2'b01) && bus.Addr[0]) ||
                        (bus.Size[1] && (bus.Addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte enables for the incoming request, derived from size and low address
    always_comb begin
        w_sel = 4'hF;
        case (bus.Size)
            2'b00:   w_sel = 4'b0001 << bus.Addr[1:0];
            2'b01:   w_sel = 4'b0011 << {bus.Addr[1], 1'b0};
            default: w_sel = 4'hF;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = bus.DataIn[7:0];
            2'd1:    w_byte = bus.DataIn[15:8];
            2'd2:    w_byte = bus.DataIn[23:16];
            default: w_byte = bus.DataIn[31:24];
        endcase
        w_half = r_lane[1] ? bus.DataIn[31:16] : bus.DataIn[15:0];
        case (r_size)
            2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
            default: w_ext = bus.DataIn;
        endcase
    end

    // Control FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_sel        <= 4'h0;
            r_resp_valid <= 1'b0;
            r_data_out   <= 32'h0;
            r_err        <= 1'b0;
            r_cnt        <= 8'h0;
            r_size       <= 2'b00;
            r_lane       <= 2'b00;
            r_signed     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_req_ready <= 1'b0;
                        r_mem_addr  <= {bus.Addr[31:2], 2'b00};
                        r_sel       <= w_sel;
                        r_size      <= bus.Size;
                        r_lane      <= bus.Addr[1:0];
                        r_signed    <= bus.Signed;
                        r_cnt       <= 8'h0;
                        if (w_misalign) begin
                            // Rejected without touching memory
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                            r_data_out   <= 32'h0;
                        end else begin
                            r_state  <= S_WAIT;
                            r_mem_rd <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // An ack on the timeout edge still counts as a good read
                    if (bus.MemAck) begin
                        r_state      <= S_RESP;
                        r_mem_rd     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_err        <= 1'b0;
                        r_data_out   <= w_ext;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == C_TIMEOUT) begin
                            r_state      <= S_RESP;
                            r_mem_rd     <= 1'b0;
                            r_resp_valid <= 1'b1;
                            r_err        <= 1'b1;
                            r_data_out   <= 32'h0;
                        end
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_rd    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ReqReady  = r_req_ready;
    assign bus.MemRd     = r_mem_rd;
    assign bus.MemAddr   = r_mem_addr;
    assign bus.SelOut    = r_sel;
    assign bus.RespValid = r_resp_valid;
    assign bus.DataOut   = r_data_out;
    assign bus.Err       = r_err;

endmodule
`default_nettype wire
